// File: rtl/spi_cfg_master.sv
// SPI master for converter register configuration and readback with programmable
// word width, SCLK divider, SPI mode, bit order and chip-select count.
module spi_cfg_master #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CS    = 2,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0,
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              sdin,
    input  logic              sdout,
    output logic [NUM_CS-1:0] cs
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HC_W  = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST    = HC_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        LAG
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [HC_W-1:0]   hcnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;

    logic sel_ok;
    logic div_end;
    logic last_half;
    logic accept;
    logic reject;
    logic lead_edge;
    logic trail_edge;
    logic finish;
    logic sample;
    logic advance;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w, input logic b);
        return LSB_FIRST ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        for (int i = 0; i < NUM_CS; i++) begin
            v[i] = (int'(sel) != i);
        end
        return v;
    endfunction

    assign sel_ok    = (int'(cs_sel) < NUM_CS);
    assign div_end   = (cnt == '0);
    assign last_half = (hcnt == HC_LAST);

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        reject     = 1'b0;
        lead_edge  = 1'b0;
        trail_edge = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        accept    = 1'b1;
                        state_nxt = LEAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            LEAD: begin
                if (div_end) state_nxt = SHIFT;
            end
            SHIFT: begin
                // Even half-period index ends on a leading sclk edge, odd on a trailing one.
                if (div_end) begin
                    lead_edge  = ~hcnt[0];
                    trail_edge = hcnt[0];
                    if (last_half) state_nxt = LAG;
                end
            end
            LAG: begin
                if (div_end) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sample  = 1'b0;
        advance = 1'b0;
        if (CPHA) begin
            sample  = trail_edge;
            advance = lead_edge;
        end else begin
            // Mode 0 puts the first bit out at cs assertion, so the final trailing edge has nothing left to shift.
            sample  = lead_edge;
            advance = trail_edge & ~last_half;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            cnt     <= CNT_RELOAD;
            hcnt    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rx_data <= '0;
            sclk    <= CPOL;
            sdin    <= 1'b0;
            cs      <= '1;
        end else begin
            state <= state_nxt;
            done  <= finish;
            err   <= reject;

            if (state == IDLE || div_end) cnt <= CNT_RELOAD;
            else                          cnt <= cnt - CNT_W'(1);

            if (state != SHIFT) hcnt <= '0;
            else if (div_end)   hcnt <= hcnt + HC_W'(1);

            if (state == SHIFT && div_end) sclk <= ~sclk;

            if (accept) begin
                busy <= 1'b1;
                cs   <= cs_decode(cs_sel);
            end else if (finish) begin
                busy    <= 1'b0;
                cs      <= '1;
                rx_data <= rx_sh;
            end

            if (accept && !CPHA) sdin <= first_bit(tx_data);
            else if (advance)    sdin <= first_bit(tx_sh);
            else if (finish)     sdin <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (accept)       tx_sh <= CPHA ? tx_data : drop_bit(tx_data);
        else if (advance) tx_sh <= drop_bit(tx_sh);
        if (sample)       rx_sh <= push_bit(rx_sh, sdout);
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: three instances cover mode 0 loopback,
// mode 3 with a device model and rejected selects, and a 24-bit LSB-first fast divider.
module tb_spi_cfg_master;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // Instance A: defaults, sdout looped back to sdin
    logic        a_start = 1'b0;
    logic        a_cs_sel = 1'b0;
    logic [15:0] a_tx = '0;
    logic        a_busy, a_done, a_err, a_sclk, a_sdin, a_sdout;
    logic [15:0] a_rx;
    logic [1:0]  a_cs;
    assign a_sdout = a_sdin;

    spi_cfg_master u_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(a_start), .cs_sel(a_cs_sel),
        .tx_data(a_tx), .busy(a_busy), .done(a_done), .err(a_err), .rx_data(a_rx),
        .sclk(a_sclk), .sdin(a_sdin), .sdout(a_sdout), .cs(a_cs)
    );

    // Instance B: CPOL=1 CPHA=1, three selects, device model on sdout
    logic        b_start = 1'b0;
    logic [1:0]  b_cs_sel = '0;
    logic [15:0] b_tx = '0;
    logic        b_busy, b_done, b_err, b_sclk, b_sdin;
    logic        b_sdout = 1'b0;
    logic [15:0] b_rx;
    logic [2:0]  b_cs;

    spi_cfg_master #(.NUM_CS(3), .CPOL(1'b1), .CPHA(1'b1)) u_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(b_start), .cs_sel(b_cs_sel),
        .tx_data(b_tx), .busy(b_busy), .done(b_done), .err(b_err), .rx_data(b_rx),
        .sclk(b_sclk), .sdin(b_sdin), .sdout(b_sdout), .cs(b_cs)
    );

    // Instance C: 24-bit, CLK_DIV=1, LSB first, loopback
    logic        c_start = 1'b0;
    logic        c_cs_sel = 1'b0;
    logic [23:0] c_tx = '0;
    logic        c_busy, c_done, c_err, c_sclk, c_sdin, c_sdout;
    logic [23:0] c_rx;
    logic [1:0]  c_cs;
    assign c_sdout = c_sdin;

    spi_cfg_master #(.DATA_W(24), .CLK_DIV(1), .LSB_FIRST(1'b1)) u_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(c_start), .cs_sel(c_cs_sel),
        .tx_data(c_tx), .busy(c_busy), .done(c_done), .err(c_err), .rx_data(c_rx),
        .sclk(c_sclk), .sdin(c_sdin), .sdout(c_sdout), .cs(c_cs)
    );

    // Pin monitors, sampled on the falling sys_clk edge
    logic        a_sclk_q = 1'b0;
    logic [1:0]  a_cs_q = 2'b11;
    logic [15:0] a_word = '0;
    int a_pulses = 0, a_busy_cyc = 0, a_cs0_low = 0, a_dones = 0, a_viol = 0;
    int a_gap = 0, a_last_gap = -1;

    always @(negedge sys_clk) begin
        if (a_sclk === 1'b1 && a_sclk_q === 1'b0) begin
            a_pulses <= a_pulses + 1;
            a_word   <= {a_word[14:0], a_sdin};
        end
        if (a_sclk !== a_sclk_q && a_cs === 2'b11 && a_cs_q === 2'b11) a_viol <= a_viol + 1;
        if (a_cs === 2'b00) a_viol <= a_viol + 1;
        if (a_busy === 1'b1) a_busy_cyc <= a_busy_cyc + 1;
        if (a_cs[0] === 1'b0) a_cs0_low <= a_cs0_low + 1;
        if (a_done === 1'b1) a_dones <= a_dones + 1;
        if (a_cs === 2'b11) begin
            a_gap <= a_gap + 1;
        end else begin
            if (a_gap != 0) a_last_gap <= a_gap;
            a_gap <= 0;
        end
        a_sclk_q <= a_sclk;
        a_cs_q   <= a_cs;
    end

    logic        b_sclk_q = 1'b1;
    logic [2:0]  b_cs_q = 3'b111;
    logic [15:0] b_word = '0;
    logic [15:0] b_dev = 16'h1234;
    int b_idx = 0, b_pulses = 0, b_cs0_low = 0, b_other_low = 0, b_idle_bad = 0;

    always @(negedge sys_clk) begin
        if (b_cs === 3'b111) begin
            b_idx <= 0;
        end else if (b_sclk === 1'b0 && b_sclk_q === 1'b1 && b_idx < 16) begin
            b_sdout <= b_dev[15 - b_idx];
            b_idx   <= b_idx + 1;
        end
        if (b_sclk === 1'b1 && b_sclk_q === 1'b0) begin
            b_pulses <= b_pulses + 1;
            b_word   <= {b_word[14:0], b_sdin};
        end
        if (b_cs[0] === 1'b0) b_cs0_low <= b_cs0_low + 1;
        if (b_cs[2:1] !== 2'b11) b_other_low <= b_other_low + 1;
        if (b_cs === 3'b111 && b_cs_q === 3'b111 && b_sclk !== 1'b1) b_idle_bad <= b_idle_bad + 1;
        b_sclk_q <= b_sclk;
        b_cs_q   <= b_cs;
    end

    logic        c_sclk_q = 1'b0;
    logic [23:0] c_word = '0;
    int c_pulses = 0, c_busy_cyc = 0, c_ones = 0, c_cs_low = 0;

    always @(negedge sys_clk) begin
        if (c_sclk === 1'b1 && c_sclk_q === 1'b0) begin
            c_pulses <= c_pulses + 1;
            c_word   <= {c_sdin, c_word[23:1]};
            if (c_sdin === 1'b1) c_ones <= c_ones + 1;
        end
        if (c_busy === 1'b1) c_busy_cyc <= c_busy_cyc + 1;
        if (c_cs !== 2'b11) c_cs_low <= c_cs_low + 1;
        c_sclk_q <= c_sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int which, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if ((which == 0 && a_done === 1'b1) || (which == 1 && b_done === 1'b1) ||
                (which == 2 && c_done === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    int   p0, bc0, l0, d0, o0;
    logic ok;

    initial begin
        // Reset state
        repeat (4) @(negedge sys_clk);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_a_err", 32'(a_err), 32'd0);
        check("rst_a_rx", 32'(a_rx), 32'd0);
        check("rst_a_sclk", 32'(a_sclk), 32'd0);
        check("rst_a_sdin", 32'(a_sdin), 32'd0);
        check("rst_a_cs", 32'(a_cs), 32'h3);
        check("rst_b_sclk", 32'(b_sclk), 32'd1);
        check("rst_b_cs", 32'(b_cs), 32'h7);
        check("rst_c_cs", 32'(c_cs), 32'h3);
        check("rst_c_err", 32'(c_err), 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Mode 0 loopback, A55A on cs[0]
        p0 = a_pulses; bc0 = a_busy_cyc; l0 = a_cs0_low; d0 = a_dones;
        a_tx = 16'hA55A; a_cs_sel = 1'b0; a_start = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        check("t1_busy_up", 32'(a_busy), 32'd1);
        check("t1_cs_low", 32'(a_cs), 32'h2);
        wait_done(0, ok);
        check("t1_done_seen", 32'(ok), 32'd1);
        check("t1_rx", 32'(a_rx), 32'hA55A);
        @(negedge sys_clk);
        check("t1_busy_cycles", 32'(a_busy_cyc - bc0), 32'd136);
        check("t1_cs0_low_cycles", 32'(a_cs0_low - l0), 32'd136);
        check("t1_pulses", 32'(a_pulses - p0), 32'd16);
        check("t1_sdin_word", 32'(a_word), 32'hA55A);
        check("t1_dones", 32'(a_dones - d0), 32'd1);
        check("t1_cs_idle", 32'(a_cs), 32'h3);
        check("t1_sdin_idle", 32'(a_sdin), 32'd0);

        // Mode 3 with device returning 1234
        p0 = b_pulses; l0 = b_cs0_low;
        b_tx = 16'hC3A5; b_cs_sel = 2'd0; b_start = 1'b1;
        @(negedge sys_clk);
        b_start = 1'b0;
        check("t2_cs_low", 32'(b_cs), 32'h6);
        wait_done(1, ok);
        check("t2_done_seen", 32'(ok), 32'd1);
        check("t2_rx", 32'(b_rx), 32'h1234);
        @(negedge sys_clk);
        check("t2_pulses", 32'(b_pulses - p0), 32'd16);
        check("t2_sdin_word", 32'(b_word), 32'hC3A5);
        check("t2_cs0_low_cycles", 32'(b_cs0_low - l0), 32'd136);
        check("t2_other_cs_low", 32'(b_other_low), 32'd0);
        check("t2_sclk_idle_bad", 32'(b_idle_bad), 32'd0);
        check("t2_sclk_idle", 32'(b_sclk), 32'd1);

        // Out-of-range select is rejected
        p0 = b_pulses;
        b_cs_sel = 2'd3; b_start = 1'b1;
        @(negedge sys_clk);
        b_start = 1'b0;
        check("t3_err_pulse", 32'(b_err), 32'd1);
        check("t3_busy_low", 32'(b_busy), 32'd0);
        check("t3_cs_high", 32'(b_cs), 32'h7);
        @(negedge sys_clk);
        check("t3_err_one_cycle", 32'(b_err), 32'd0);
        repeat (10) @(negedge sys_clk);
        check("t3_no_pulses", 32'(b_pulses - p0), 32'd0);
        check("t3_sclk_idle", 32'(b_sclk), 32'd1);
        check("t3_rx_held", 32'(b_rx), 32'h1234);

        // Back-to-back frames with start held high
        d0 = a_dones;
        a_tx = 16'h0001; a_cs_sel = 1'b0; a_start = 1'b1;
        @(negedge sys_clk);
        check("t4_busy_up", 32'(a_busy), 32'd1);
        a_tx = 16'h8000;
        wait_done(0, ok);
        check("t4_done1_seen", 32'(ok), 32'd1);
        check("t4_rx1", 32'(a_rx), 32'h0001);
        wait_done(0, ok);
        a_start = 1'b0;
        check("t4_done2_seen", 32'(ok), 32'd1);
        check("t4_rx2", 32'(a_rx), 32'h8000);
        check("t4_cs_gap", 32'(a_last_gap), 32'd1);
        check("t4_sdin_word2", 32'(a_word), 32'h8000);
        repeat (2) @(negedge sys_clk);
        check("t4_no_third", 32'(a_busy), 32'd0);
        check("t4_dones", 32'(a_dones - d0), 32'd2);

        // Reset in the middle of a frame
        d0 = a_dones; p0 = a_pulses;
        a_tx = 16'hFFFF; a_start = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (a_pulses - p0 == 7) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reached_bit7", 32'(ok), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("t5_cs", 32'(a_cs), 32'h3);
        check("t5_sclk", 32'(a_sclk), 32'd0);
        check("t5_busy", 32'(a_busy), 32'd0);
        check("t5_done", 32'(a_done), 32'd0);
        check("t5_rx", 32'(a_rx), 32'd0);
        check("t5_sdin", 32'(a_sdin), 32'd0);
        repeat (150) @(negedge sys_clk);
        check("t5_no_done", 32'(a_dones - d0), 32'd0);
        a_tx = 16'h3C96; a_start = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        wait_done(0, ok);
        check("t5_after_done", 32'(ok), 32'd1);
        check("t5_after_rx", 32'(a_rx), 32'h3C96);
        check("t5_overlap_viol", 32'(a_viol), 32'd0);

        // 24-bit LSB-first, CLK_DIV=1
        p0 = c_pulses; bc0 = c_busy_cyc; o0 = c_ones;
        c_tx = 24'h000001; c_start = 1'b1;
        @(negedge sys_clk);
        c_start = 1'b0;
        wait_done(2, ok);
        check("t6_done_seen", 32'(ok), 32'd1);
        check("t6_rx", 32'(c_rx), 32'h000001);
        @(negedge sys_clk);
        check("t6_busy_cycles", 32'(c_busy_cyc - bc0), 32'd50);
        check("t6_pulses", 32'(c_pulses - p0), 32'd24);
        check("t6_sdin_word", 32'(c_word), 32'h000001);
        check("t6_sdin_ones", 32'(c_ones - o0), 32'd1);
        l0 = c_cs_low;
        c_tx = 24'hA5C301; c_start = 1'b1;
        @(negedge sys_clk);
        c_start = 1'b0;
        wait_done(2, ok);
        check("t6b_done_seen", 32'(ok), 32'd1);
        check("t6b_rx", 32'(c_rx), 32'hA5C301);
        @(negedge sys_clk);
        check("t6b_sdin_word", 32'(c_word), 32'hA5C301);
        check("t6b_cs_low_cycles", 32'(c_cs_low - l0), 32'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
